// File: rtl/rm_pkg.sv
// rm_pkg: shared types and default sizing for the runtime-monitor report path.
//   rm_report_entry_t : one queued report (masked report vector + timestamp)
//   RM_NUM_REPORTS_C1 : report width of automata cluster 1
//   RM_REPORT_DEPTH   : default report FIFO depth
//   RM_TS_WIDTH       : default symbol timestamp width
//   RM_DROP_WIDTH     : default drop counter width
package rm_pkg;

    localparam int RM_NUM_REPORTS_C1 = 36;
    localparam int RM_REPORT_DEPTH   = 8;
    localparam int RM_TS_WIDTH       = 32;
    localparam int RM_DROP_WIDTH     = 16;

    typedef struct packed {
        logic [RM_NUM_REPORTS_C1-1:0] reports;
        logic [RM_TS_WIDTH-1:0]       timestamp;
    } rm_report_entry_t;

endpackage

// File: rtl/rm_report_collector_if.sv
// rm_report_collector_if: bundles the cluster-side inputs and the
// consumer-side queue outputs of rm_report_collector.
//   slave  : collector view (takes run/clear/reports, drives the head entry)
//   master : testbench / consumer view
// Signals: run, clear, reports_in, report_en, out_valid, out_ready,
//          out_reports, out_timestamp, level, overflow, drop_cnt.
interface rm_report_collector_if
    import rm_pkg::*;
#(
    parameter int NUM_REPORTS = RM_NUM_REPORTS_C1,
    parameter int DEPTH       = RM_REPORT_DEPTH,
    parameter int TS_WIDTH    = RM_TS_WIDTH,
    parameter int DROP_WIDTH  = RM_DROP_WIDTH
);
    logic                         run;
    logic                         clear;
    logic [NUM_REPORTS-1:0]       reports_in;
    logic [NUM_REPORTS-1:0]       report_en;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_REPORTS-1:0]       out_reports;
    logic [TS_WIDTH-1:0]          out_timestamp;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic                         overflow;
    logic [DROP_WIDTH-1:0]        drop_cnt;

    modport slave (
        input  run, clear, reports_in, report_en, out_ready,
        output out_valid, out_reports, out_timestamp, level, overflow, drop_cnt
    );

    modport master (
        output run, clear, reports_in, report_en, out_ready,
        input  out_valid, out_reports, out_timestamp, level, overflow, drop_cnt
    );
endinterface

// File: rtl/rm_sync_fifo.sv
// rm_sync_fifo: single-clock FIFO with flop storage.
//   clk, reset (sync, active low), flush (sync, empties the queue)
//   push/wdata : write tail; accepted when not full or when popping together
//   pop/rdata  : read head; rdata reads 0 while empty
//   full, empty, level : status derived from the registered pointers
module rm_sync_fifo
    import rm_pkg::*;
#(
    parameter int WIDTH = RM_NUM_REPORTS_C1,
    parameter int DEPTH = RM_REPORT_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW:0]                  rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
    logic                         do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // When full, a same-cycle pop frees the head slot, which is exactly
    // the slot the write pointer addresses.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/rm_report_collector.sv
// rm_report_collector: queues masked report vectors from one automata
// cluster for the core-side consumer.
//   clk   : single clock
//   reset : synchronous, active-low
//   bus   : rm_report_collector_if.slave
//           in  run, clear, reports_in, report_en, out_ready
//           out out_valid, out_reports, out_timestamp, level, overflow, drop_cnt
// Optional feature macro: RM_REPORT_TIMESTAMP_EN
//   defined   : a symbol counter advances on run and is stored with each entry
//   undefined : no counter or timestamp storage; out_timestamp is tied to 0
module rm_report_collector
    import rm_pkg::*;
#(
    parameter int NUM_REPORTS = RM_NUM_REPORTS_C1,
    parameter int DEPTH       = RM_REPORT_DEPTH,
    parameter int TS_WIDTH    = RM_TS_WIDTH,
    parameter int DROP_WIDTH  = RM_DROP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    rm_report_collector_if.slave  bus
);
    localparam int LW = $clog2(DEPTH+1);

    logic [NUM_REPORTS-1:0] masked;
    logic                   hit, pop, push, drop;
    logic                   fifo_full, fifo_empty;
    logic [LW-1:0]          fifo_level;
    logic [DROP_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   overflow_q, overflow_d;

    assign masked = bus.reports_in & bus.report_en;
    assign hit    = bus.run && (|masked);
    assign pop    = bus.out_valid && bus.out_ready;
    // clear overrides everything: the flush empties the queue and any
    // hit in that cycle is neither queued nor counted as a drop.
    assign push   = hit && (!fifo_full || pop) && !bus.clear;
    assign drop   = hit && fifo_full && !pop && !bus.clear;

`ifdef RM_REPORT_TIMESTAMP_EN
    typedef struct packed {
        logic [NUM_REPORTS-1:0] reports;
        logic [TS_WIDTH-1:0]    timestamp;
    } entry_t;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    entry_t              wr_entry, rd_entry;

    // Keeps counting through clear; only reset zeroes it.
    always_comb begin
        ts_d = ts_q;
        if (bus.run) ts_d = ts_q + TS_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_d;
    end

    assign wr_entry.reports   = masked;
    assign wr_entry.timestamp = ts_q;

    rm_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.clear),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.out_reports   = rd_entry.reports;
    assign bus.out_timestamp = rd_entry.timestamp;
`else
    logic [NUM_REPORTS-1:0] rd_reports;

    rm_sync_fifo #(.WIDTH(NUM_REPORTS), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.clear),
        .push  (push),
        .pop   (pop),
        .wdata (masked),
        .rdata (rd_reports),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.out_reports   = rd_reports;
    assign bus.out_timestamp = {TS_WIDTH{1'b0}};
`endif

    assign bus.out_valid = !fifo_empty;
    assign bus.level     = fifo_level;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (bus.clear) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DROP_WIDTH{1'b1}})
                drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_rm_report_collector.sv
// tb_rm_report_collector: directed scenarios plus a randomized phase, with a
// queue-based reference model compared against the DUT every cycle.
module tb_rm_report_collector;
    import rm_pkg::*;

    localparam int NR    = RM_NUM_REPORTS_C1;
    localparam int DEPTH = RM_REPORT_DEPTH;
    localparam int TSW   = RM_TS_WIDTH;
    localparam int DW    = RM_DROP_WIDTH;
`ifdef RM_REPORT_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rm_report_collector_if #(.NUM_REPORTS(NR), .DEPTH(DEPTH), .TS_WIDTH(TSW), .DROP_WIDTH(DW)) bus ();

    rm_report_collector #(.NUM_REPORTS(NR), .DEPTH(DEPTH), .TS_WIDTH(TSW), .DROP_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    rm_report_entry_t mq[$];
    logic [TSW-1:0]   m_ts;
    logic [DW-1:0]    m_drop;
    bit               m_ovf;
    bit               m_hit, m_pop, m_full;
    rm_report_entry_t m_e;

    initial begin
        mq.delete();
        m_ts = '0; m_drop = '0; m_ovf = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mq.delete();
                m_ts = '0; m_drop = '0; m_ovf = 1'b0;
            end else begin
                m_hit  = bus.run && ((bus.reports_in & bus.report_en) != '0);
                m_pop  = (mq.size() != 0) && bus.out_ready;
                m_full = (mq.size() == DEPTH);
                m_e.reports   = bus.reports_in & bus.report_en;
                m_e.timestamp = m_ts;
                if (bus.clear) begin
                    mq.delete();
                    m_drop = '0;
                    m_ovf  = 1'b0;
                end else begin
                    if (m_pop) void'(mq.pop_front());
                    if (m_hit) begin
                        if (!m_full || m_pop) mq.push_back(m_e);
                        else begin
                            m_ovf = 1'b1;
                            if (m_drop != '1) m_drop = m_drop + 1'b1;
                        end
                    end
                end
                if (bus.run) m_ts = m_ts + 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [63:0] e_rep, e_ts;
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'bx) begin
                e_rep = (mq.size() != 0) ? 64'(mq[0].reports) : 64'd0;
                e_ts  = (mq.size() != 0 && TS_EN) ? 64'(mq[0].timestamp) : 64'd0;
                check("cyc_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
                check("cyc_level", 64'(bus.level), 64'(mq.size()));
                check("cyc_reports", 64'(bus.out_reports), e_rep);
                check("cyc_timestamp", 64'(bus.out_timestamp), e_ts);
                check("cyc_overflow", 64'(bus.overflow), 64'(m_ovf));
                check("cyc_drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic run, input logic clr, input logic [NR-1:0] rin,
                         input logic [NR-1:0] ren, input logic rdy);
        bus.run = run; bus.clear = clr; bus.reports_in = rin;
        bus.report_en = ren; bus.out_ready = rdy;
    endtask

    function automatic logic [NR-1:0] rnd_rep();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[NR-1:0];
    endfunction

    logic [NR-1:0] ones, bit5;

    initial begin
        ones = '1;
        bit5 = '0;
        bit5[5] = 1'b1;
        reset = 1'b0;
        drive(0, 0, '0, '0, 0);
        tick(2);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_level", 64'(bus.level), 64'd0);
        reset = 1'b1;

        // Single hit at ts=3
        drive(1, 0, '0, ones, 0);
        tick(3);
        drive(1, 0, bit5, ones, 0);
        tick(1);
        drive(0, 0, '0, ones, 0);
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_reports", 64'(bus.out_reports), 64'h20);
        check("single_ts", 64'(bus.out_timestamp), TS_EN ? 64'd3 : 64'd0);
        check("single_level", 64'(bus.level), 64'd1);
        tick(2);
        check("single_stable", 64'(bus.out_reports), 64'h20);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;

        // Masked bit and idle cycle
        begin
            logic [NR-1:0] en_no5;
            en_no5 = ones;
            en_no5[5] = 1'b0;
            drive(1, 0, bit5, en_no5, 0);
            tick(1);
            drive(0, 0, ones, ones, 0);
            tick(1);
            check("mask_idle_level", 64'(bus.level), 64'd0);
        end

        // Overflow: 10 hits from ts=0 into an 8-deep queue
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, rnd_rep() | NR'(1), ones, 0);
            tick(1);
        end
        drive(0, 0, '0, ones, 0);
        check("ovf_level", 64'(bus.level), 64'd8);
        check("ovf_drop", 64'(bus.drop_cnt), 64'd2);
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check("drain_ts", 64'(bus.out_timestamp), TS_EN ? 64'(i) : 64'd0);
            bus.out_ready = 1'b1;
            tick(1);
        end
        bus.out_ready = 1'b0;
        check("drain_empty", 64'(bus.out_valid), 64'd0);

        // Full with a simultaneous pop: no drop
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, rnd_rep() | NR'(2), ones, 0);
            tick(1);
        end
        drive(1, 0, bit5, ones, 1);
        tick(1);
        drive(0, 0, '0, ones, 0);
        check("fullpop_level", 64'(bus.level), 64'd8);
        check("fullpop_drop", 64'(bus.drop_cnt), 64'd2);

        // Clear precedence with a queue of 3
        drive(0, 1, '0, ones, 0);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, bit5, ones, 0);
            tick(1);
        end
        drive(1, 1, bit5, ones, 1);
        tick(1);
        drive(0, 0, '0, ones, 0);
        check("clr_level", 64'(bus.level), 64'd0);
        check("clr_valid", 64'(bus.out_valid), 64'd0);
        check("clr_drop", 64'(bus.drop_cnt), 64'd0);
        check("clr_ovf", 64'(bus.overflow), 64'd0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0,
                  ($urandom_range(0, 2) == 0) ? rnd_rep() : '0,
                  ($urandom_range(0, 3) == 0) ? rnd_rep() : ones,
                  $urandom_range(0, 2) == 0);
            tick(1);
        end

        // Drop counter saturation, then reset
        drive(0, 1, '0, ones, 0);
        tick(1);
        drive(1, 0, ones, ones, 0);
        tick(70010);
        drive(0, 0, '0, ones, 0);
        check("sat_drop", 64'(bus.drop_cnt), 64'd65535);
        check("sat_ovf", 64'(bus.overflow), 64'd1);
        reset = 1'b0;
        tick(1);
        check("rst2_valid", 64'(bus.out_valid), 64'd0);
        check("rst2_level", 64'(bus.level), 64'd0);
        check("rst2_reports", 64'(bus.out_reports), 64'd0);
        check("rst2_ts", 64'(bus.out_timestamp), 64'd0);
        check("rst2_drop", 64'(bus.drop_cnt), 64'd0);
        check("rst2_ovf", 64'(bus.overflow), 64'd0);
        reset = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
